dice_multi: RTL and testbench
=============================

Name: dice_multi

Overview:
- Parametrised successor to the single-die electronic dice: N_DICE dice, each with N_FACES faces.
- Features: synchronised and debounced button, two roll modes (odometer counting or LFSR-scrambled), decelerating settle phase after release, registered sum with valid flag, and a throw counter.
- Sits between the board push-button and the display/score logic.

Parameters:
- N_DICE, 2, number of dice (1..16).
- N_FACES, 6, faces per die (2..15); faces take values 1..N_FACES, and 0 means blank.
- DEBOUNCE, 4, consecutive stable synchronised samples needed to accept a button change (>=1).
- SETTLE_STEPS, 4, number of advances performed after release (>=1).
- FACE_W, derived = $clog2(N_FACES+1), width of one face.
- SUM_W, derived = $clog2(N_DICE*N_FACES+1), width of the total.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- button  in  1  raw push-button, asynchronous to clk.
- mode  in  1  0 = odometer, 1 = LFSR scramble; sampled on ROLL entry.
- throw  out  N_DICE*FACE_W  die i occupies bits [i*FACE_W +: FACE_W].
- total  out  SUM_W  sum of all faces; updated on SHOW entry.
- valid  out  1  high while in SHOW.
- rolls  out  8  completed throws, saturating at 255.

Behaviour:
- Reset: rst low asynchronously forces all dice=0, total=0, valid=0, rolls=0, state=IDLE, LFSR=16'hACE1, synchroniser/debounce cleared (btn_db=0).
- Button path:
  - 2-flop synchroniser feeds the debounce counter.
  - btn_db toggles once the synchronised value has differed from btn_db for DEBOUNCE consecutive cycles.
  - A raw edge held stable reaches btn_db 2+DEBOUNCE cycles later; the FSM reacts on the next edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in every state except reset, so press timing supplies the entropy.
- Advance of die i with step s: next = cur+s; if next>N_FACES then next -= N_FACES. Starting from 0 this yields 1 or 2, so blank is never re-entered.
- Step per advance:
  - Mode 0: die0 steps 1. Die i>0 steps 1 only if every lower die wraps (N_FACES->1) in the same advance; otherwise die i holds.
  - Mode 1: die i steps 1+lfsr[i], every die on every advance.
- FSM states IDLE, ROLL, SETTLE, SHOW (enum):
  - IDLE: dice hold. btn_db=1 -> ROLL; latch mode.
  - ROLL: one advance per cycle, including the entry cycle's next edge. btn_db=0 -> SETTLE with k=0, gap counter cleared.
  - SETTLE: advance k (k=0..SETTLE_STEPS-1) fires k+1 cycles after the previous advance (or after SETTLE entry). Total settle length is SETTLE_STEPS*(SETTLE_STEPS+1)/2 cycles.
    - On the edge of the last advance, go to SHOW.
    - btn_db=1 at any point -> ROLL, re-latching mode; settle progress is discarded.
  - SHOW: dice hold, valid=1. total = registered sum of the final faces, visible in the same cycle valid rises. rolls increments (saturating) on entry. btn_db=1 -> ROLL, and valid drops on that transition edge.
- total and valid change only on SHOW entry/exit; total holds its last value outside SHOW.
- Reset mid-operation: immediate return to reset values. rolls is also cleared.
- Simultaneous events: a debounced press in the same cycle SETTLE would complete gives ROLL priority (no SHOW, rolls unchanged).

Decomposition:
- Package dice_pkg holds:
  - state enum {IDLE, ROLL, SETTLE, SHOW};
  - LFSR_SEED=16'hACE1 and the tap mask;
  - the face-advance function (cur, step, n_faces).
- One sub-module, btn_debounce (synchroniser + counter, parameter DEBOUNCE). Dice, FSM, LFSR and sum stay in dice_multi.

Test Plan:
- Reset: assert rst low mid-ROLL, asynchronous to clk -> throw=0, total=0, valid=0, rolls=0 without waiting for an edge; after release the block stays IDLE with button low.
- Odometer counting (N_DICE=2, N_FACES=6, mode=0): hold button so exactly 3 ROLL advances occur, then release -> 4 settle advances at gaps 1,2,3,4 cycles. After 7 total advances, die0=1, die1=1; SHOW with total=2, valid=1, rolls=1.
- Carry/wrap: mode=0, 36 advances from reset state -> die0=6, die1=5; the 37th gives die0=1, die1=6.
- Debounce: 1-cycle and 3-cycle glitches with DEBOUNCE=4 -> no state change. A 4-cycle-stable press -> ROLL entered exactly 2+4+1 edges after the raw edge.
- Re-press in SETTLE: press during settle step 2 -> back to ROLL, valid stays 0, rolls unchanged. Re-press in SHOW: valid drops on the ROLL edge, total keeps its old value.
- Mode 1 and saturation: LFSR mode with 300 throws -> every face always in 1..6, total equals the sum of faces at each SHOW, rolls saturates at 255.

Source files
------------

// File: rtl/dice_pkg.sv
`default_nettype none
// dice_pkg: shared state encoding, LFSR constants and the face-advance rule for dice_multi.

package dice_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL   = 2'd1,
    SETTLE = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Five bits hold the worst case of 15 + 2 before the wrap is removed.
  function automatic logic [4:0] face_advance(input logic [4:0] cur,
                                              input logic [4:0] step,
                                              input logic [4:0] n_faces);
    logic [4:0] nxt;
    nxt = cur + step;
    if (nxt > n_faces) nxt = nxt - n_faces;
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// btn_debounce: two-flop synchroniser followed by a stable-sample counter;
// btn_db follows the synchronised button after DEBOUNCE consecutive differing samples.

module btn_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_db
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync2 != btn_db) begin
        if (cnt == CNT_W'(DEBOUNCE - 1)) begin
          btn_db <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dice_multi.sv
`default_nettype none
// dice_multi: N_DICE electronic dice with debounced button, odometer or LFSR roll,
// decelerating settle phase, registered total with valid flag and a saturating throw counter.

module dice_multi
  import dice_pkg::*;
#(
  parameter int N_DICE       = 2,
  parameter int N_FACES      = 6,
  parameter int DEBOUNCE     = 4,
  parameter int SETTLE_STEPS = 4,
  parameter int FACE_W       = $clog2(N_FACES + 1),
  parameter int SUM_W        = $clog2(N_DICE * N_FACES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     button,
  input  logic                     mode,
  output logic [N_DICE*FACE_W-1:0] throw,
  output logic [SUM_W-1:0]         total,
  output logic                     valid,
  output logic [7:0]               rolls
);

  localparam int STEP_W = $clog2(SETTLE_STEPS + 1);

  logic              btn_db;
  state_t            state, state_n;
  logic [15:0]       lfsr;
  logic              mode_q, mode_n;
  logic [STEP_W-1:0] k, k_n, gap, gap_n;
  logic              adv;
  logic [FACE_W-1:0] dice   [N_DICE];
  logic [FACE_W-1:0] dice_n [N_DICE];
  logic [N_DICE-1:0] carry;
  logic [SUM_W-1:0]  sum_n, total_n;
  logic [7:0]        rolls_n;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .btn_db (btn_db)
  );

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N_DICE; i++) begin : g_die
    logic [4:0] step;
    // Odometer: a die moves only when every lower die rolls over N_FACES -> 1.
    if (i > 0) begin : g_carry
      assign carry[i] = carry[i-1] & (dice[i-1] == FACE_W'(N_FACES));
    end
    assign step      = mode_q ? ({4'd0, lfsr[i]} + 5'd1) : {4'd0, carry[i]};
    assign dice_n[i] = adv ? FACE_W'(face_advance(5'(dice[i]), step, 5'(N_FACES)))
                           : dice[i];
    assign throw[i*FACE_W +: FACE_W] = dice[i];
  end

  always_comb begin
    sum_n = '0;
    for (int i = 0; i < N_DICE; i++) sum_n = sum_n + SUM_W'(dice_n[i]);
  end

  assign valid = (state == SHOW);

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    k_n     = k;
    gap_n   = gap;
    adv     = 1'b0;
    total_n = total;
    rolls_n = rolls;
    unique case (state)
      IDLE: begin
        if (btn_db) begin
          state_n = ROLL;
          mode_n  = mode;
        end
      end
      ROLL: begin
        if (btn_db) begin
          adv = 1'b1;
        end else begin
          state_n = SETTLE;
          k_n     = '0;
          gap_n   = '0;
        end
      end
      SETTLE: begin
        // A fresh press outranks a pending advance or SHOW entry.
        if (btn_db) begin
          state_n = ROLL;
          mode_n  = mode;
        end else if (gap == k) begin
          adv   = 1'b1;
          gap_n = '0;
          k_n   = k + 1'b1;
          if (k == STEP_W'(SETTLE_STEPS - 1)) begin
            state_n = SHOW;
            total_n = sum_n;
            rolls_n = (rolls == 8'hFF) ? rolls : rolls + 8'd1;
          end
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      SHOW: begin
        if (btn_db) begin
          state_n = ROLL;
          mode_n  = mode;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      lfsr   <= LFSR_SEED;
      mode_q <= 1'b0;
      k      <= '0;
      gap    <= '0;
      total  <= '0;
      rolls  <= '0;
      for (int i = 0; i < N_DICE; i++) dice[i] <= '0;
    end else begin
      state  <= state_n;
      lfsr   <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      mode_q <= mode_n;
      k      <= k_n;
      gap    <= gap_n;
      total  <= total_n;
      rolls  <= rolls_n;
      for (int i = 0; i < N_DICE; i++) dice[i] <= dice_n[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dice_multi.sv
`default_nettype none
// tb_dice_multi: directed scoreboard bench; expected SHOW results are queued at press time
// and a monitor compares them whenever valid rises.

module tb_dice_multi;

  logic       clk;
  logic       rst;
  logic       button;
  logic       mode;
  logic [5:0] throw;
  logic [3:0] total;
  logic       valid;
  logic [7:0] rolls;

  int checks = 0;
  int errors = 0;
  int exp_rolls = 0;

  typedef struct {
    logic [5:0] throw;
    logic [3:0] total;
    logic [7:0] rolls;
    bit         exact;
  } exp_t;

  exp_t sb[$];

  dice_multi #(
    .N_DICE(2), .N_FACES(6), .DEBOUNCE(4), .SETTLE_STEPS(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .mode   (mode),
    .throw  (throw),
    .total  (total),
    .valid  (valid),
    .rolls  (rolls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [5:0] t, input logic [3:0] s, input bit exact);
    exp_t e;
    exp_rolls = (exp_rolls == 255) ? 255 : exp_rolls + 1;
    e.throw = t;
    e.total = s;
    e.rolls = 8'(exp_rolls);
    e.exact = exact;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input logic lvl, input string name);
    int n = 0;
    while (valid !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(name, 32'(valid), 32'(lvl));
  endtask

  // Monitor: compares each SHOW entry against the oldest queued expectation.
  initial begin : monitor
    logic valid_q;
    exp_t e;
    logic [2:0] f0, f1;
    valid_q = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && valid_q !== 1'b1) begin
        if (sb.size() == 0) begin
          chk("show_unexpected", 32'(valid), 32'd0);
        end else begin
          e  = sb.pop_front();
          f0 = throw[2:0];
          f1 = throw[5:3];
          chk("show_rolls", 32'(rolls), 32'(e.rolls));
          if (e.exact) begin
            chk("show_throw", 32'(throw), 32'(e.throw));
            chk("show_total", 32'(total), 32'(e.total));
          end else begin
            chk("lfsr_face0_range", 32'(f0 >= 3'd1 && f0 <= 3'd6), 32'd1);
            chk("lfsr_face1_range", 32'(f1 >= 3'd1 && f1 <= 3'd6), 32'd1);
            chk("lfsr_total_sum", 32'(total), 32'(f0) + 32'(f1));
          end
        end
      end
      valid_q = valid;
    end
  end

  initial begin : stim
    rst = 1'b0;
    button = 1'b0;
    mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_throw", 32'(throw), 32'd0);
    chk("reset_total", 32'(total), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_rolls", 32'(rolls), 32'd0);
    rst = 1'b1;

    // Glitches shorter than the debounce window never start a roll.
    @(negedge clk); button = 1'b1;
    @(negedge clk); button = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch1_throw", 32'(throw), 32'd0);
    @(negedge clk); button = 1'b1;
    repeat (3) @(negedge clk); button = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch3_throw", 32'(throw), 32'd0);
    chk("glitch3_valid", 32'(valid), 32'd0);

    // Odometer throw: 3 ROLL advances + 4 settle advances -> (1,1).
    @(negedge clk); mode = 1'b0; button = 1'b1;
    push_exp({3'd1, 3'd1}, 4'd2, 1'b1);
    repeat (4) @(negedge clk); button = 1'b0;
    repeat (3) @(negedge clk);
    chk("roll_entry_no_advance", 32'(throw), 32'd0);
    @(negedge clk);
    chk("first_advance_edge8", 32'(throw), 32'({3'd0, 3'd1}));
    repeat (12) @(negedge clk);
    chk("settle_not_done_edge20", 32'(valid), 32'd0);
    @(negedge clk);
    chk("show_edge21", 32'(valid), 32'd1);
    repeat (5) @(negedge clk);
    chk("show_hold_total", 32'(total), 32'd2);
    chk("show_hold_valid", 32'(valid), 32'd1);

    // Re-press in SHOW, then re-press during settle step 2.
    @(negedge clk); button = 1'b1;
    push_exp({3'd3, 3'd1}, 4'd4, 1'b1);
    repeat (4) @(negedge clk); button = 1'b0;
    repeat (2) @(negedge clk);
    chk("show_before_repress", 32'(valid), 32'd1);
    @(negedge clk);
    chk("valid_drop_on_roll", 32'(valid), 32'd0);
    chk("total_kept_on_roll", 32'(total), 32'd2);
    repeat (2) @(negedge clk); button = 1'b1;
    repeat (4) @(negedge clk); button = 1'b0;
    repeat (3) @(negedge clk);
    chk("settle_abort_throw", 32'(throw), 32'({3'd1, 3'd6}));
    chk("settle_abort_valid", 32'(valid), 32'd0);
    chk("settle_abort_rolls", 32'(rolls), 32'd1);
    repeat (13) @(negedge clk);
    chk("second_settle_edge29", 32'(valid), 32'd0);
    @(negedge clk);
    chk("second_show_edge30", 32'(valid), 32'd1);

    // Asynchronous reset in the middle of a roll.
    repeat (3) @(negedge clk);
    @(negedge clk); button = 1'b1;
    repeat (12) @(negedge clk);
    #2 rst = 1'b0; button = 1'b0;
    #1;
    chk("async_rst_throw", 32'(throw), 32'd0);
    chk("async_rst_total", 32'(total), 32'd0);
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_rolls", 32'(rolls), 32'd0);
    exp_rolls = 0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("idle_after_rst_throw", 32'(throw), 32'd0);
    chk("idle_after_rst_valid", 32'(valid), 32'd0);

    // Carry chain: 36 advances -> (6,5); 37th -> (1,6); 43rd wraps both to (1,1).
    @(negedge clk); mode = 1'b0; button = 1'b1;
    push_exp({3'd5, 3'd6}, 4'd11, 1'b1);
    repeat (33) @(negedge clk); button = 1'b0;
    wait_valid(1'b1, "carry_show_timeout");
    @(negedge clk); button = 1'b1;
    push_exp({3'd1, 3'd1}, 4'd2, 1'b1);
    repeat (4) @(negedge clk); button = 1'b0;
    repeat (4) @(negedge clk);
    chk("carry_advance37", 32'(throw), 32'({3'd6, 3'd1}));
    wait_valid(1'b1, "wrap_show_timeout");

    // LFSR throws drive rolls into saturation.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); mode = 1'b1; button = 1'b1;
      push_exp(6'd0, 4'd0, 1'b0);
      repeat (4 + (i % 5)) @(negedge clk); button = 1'b0;
      wait_valid(1'b0, "lfsr_roll_timeout");
      wait_valid(1'b1, "lfsr_show_timeout");
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("rolls_saturated", 32'(rolls), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
